// File: rtl/kronos_dmem_responder_pkg.sv
// Shared Kronos types used by the data-memory responder and the LSU.
// Lane masks are lane-0 patterns; the LSU shifts them to the addressed byte.
package kronos_types;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_t;

  parameter logic [3:0] MASK_BYTE = 4'b0001;
  parameter logic [3:0] MASK_HALF = 4'b0011;
  parameter logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/kronos_dmem_responder_spram.sv
// DEPTH x 32 single-port RAM with per-byte write enables.
// The read register only updates on an enabled read, so it holds between loads.
module kronos_spram #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/kronos_dmem_responder.sv
// Slave end of the Kronos LSU req/ack data bus, backed by an internal word RAM.
// Serves one request at a time after LATENCY cycles plus any injected stalls.
module kronos_dmem_responder
  import kronos_types::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic        data_err,
  input  logic        stall_in
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t state, state_next;
  logic [3:0]  count;
  logic [31:0] addr_q;
  logic [31:0] wr_data_q;
  logic [3:0]  mask_q;
  logic        wr_en_q;
  logic        err_q;
  logic        rd_zero;
  logic        access;
  logic        ram_en;
  logic        in_range;
  logic [29:0] word;
  logic [31:0] ram_q;

  // BASE_ADDR is aligned to the RAM size, so word-granular subtraction is exact;
  // the full-width compare rejects addresses that would wrap into the RAM.
  assign word     = addr_q[31:2] - BASE_ADDR[31:2];
  assign in_range = (addr_q >= BASE_ADDR) && ({2'b00, word} < 32'(DEPTH));
  assign ram_en   = access && in_range && rstz;

  kronos_spram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (wr_en_q),
    .be    (mask_q),
    .addr  (word[AW-1:0]),
    .wdata (wr_data_q),
    .rdata (ram_q)
  );

  always_comb begin
    state_next = state;
    data_ack   = 1'b0;
    access     = 1'b0;
    case (state)
      DMEM_IDLE: begin
        if (data_req) begin
          state_next = DMEM_WAIT;
        end
      end
      DMEM_WAIT: begin
        if (!stall_in && count == 4'd0) begin
          access     = 1'b1;
          state_next = DMEM_RESP;
        end
      end
      DMEM_RESP: begin
        data_ack   = 1'b1;
        state_next = DMEM_IDLE;
      end
      default: state_next = DMEM_IDLE;
    endcase
  end

  // rd_zero forces the load bus to 0 after reset or an out-of-range access,
  // while the RAM read register keeps the last in-range load word.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      state   <= DMEM_IDLE;
      count   <= 4'd0;
      err_q   <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      state <= state_next;
      case (state)
        DMEM_IDLE: begin
          if (data_req) begin
            addr_q    <= data_addr;
            wr_data_q <= data_wr_data;
            mask_q    <= data_mask;
            wr_en_q   <= data_wr_en;
            count     <= 4'(LATENCY - 1);
          end
        end
        DMEM_WAIT: begin
          if (!stall_in && count != 4'd0) begin
            count <= count - 4'd1;
          end
        end
        default: ;
      endcase
      if (access) begin
        err_q <= !in_range;
        if (!in_range) begin
          rd_zero <= 1'b1;
        end else if (!wr_en_q) begin
          rd_zero <= 1'b0;
        end
      end
    end
  end

  assign data_err     = (state == DMEM_RESP) && err_q;
  assign data_rd_data = rd_zero ? 32'h0 : ram_q;

endmodule

// File: tb/tb_kronos_dmem_responder.sv
// Randomized scoreboard bench for kronos_dmem_responder against a transaction-level memory model.
module tb_kronos_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1000;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wr_data = '0;
  logic [3:0]  data_mask = '0;
  logic        data_wr_en = 1'b0;
  logic        data_req = 1'b0;
  logic        stall_in = 1'b0;
  logic [31:0] data_rd_data;
  logic        data_ack;
  logic        data_err;

  always #5 clk = ~clk;

  kronos_dmem_responder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .LATENCY   (LAT)
  ) dut (
    .clk          (clk),
    .rstz         (rstz),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_mask    (data_mask),
    .data_wr_en   (data_wr_en),
    .data_req     (data_req),
    .data_rd_data (data_rd_data),
    .data_ack     (data_ack),
    .data_err     (data_err),
    .stall_in     (stall_in)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          ack_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  logic        mon_on = 1'b0;
  logic        prev_ack = 1'b0;
  logic        resp_pending = 1'b0;
  logic [31:0] mem_model [DEPTH];
  logic [31:0] last_rd = '0;

  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at edge %0d", name, got, want, edge_cnt);
    end
  endtask

  // Reference memory: byte-addressed window [BASE, BASE+DEPTH*4), plain word array.
  task automatic modelAccess(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask,
                             input logic we, output logic [31:0] rd, output logic err);
    longint unsigned a, lo, hi;
    int idx;
    a  = {32'h0, addr};
    lo = {32'h0, BASE};
    hi = lo + longint'(DEPTH) * 4;
    if (a >= lo && a < hi) begin
      idx = int'((a - lo) / 4);
      err = 1'b0;
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (mask[i]) mem_model[idx][8*i +: 8] = wdata[8*i +: 8];
        end
        rd = last_rd;
      end else begin
        rd      = mem_model[idx];
        last_rd = rd;
      end
    end else begin
      err     = 1'b1;
      rd      = '0;
      last_rd = '0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask,
                               input logic we, input int nstall);
    exp_t e;
    int   waited;
    data_addr    = addr;
    data_wr_data = wdata;
    data_mask    = mask;
    data_wr_en   = we;
    data_req     = 1'b1;
    if (resp_pending) @(negedge clk);
    modelAccess(addr, wdata, mask, we, e.rd, e.err);
    e.ack_edge = edge_cnt + 1 + int'(LAT) + nstall;
    exp_q.push_back(e);
    if (nstall > 0) begin
      @(negedge clk);
      stall_in = 1'b1;
      repeat (nstall) @(negedge clk);
      stall_in = 1'b0;
    end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!data_ack && waited < 40);
    if (!data_ack) begin
      checks++;
      failures++;
      $display("[TB] FAIL ack_timeout: no ack within %0d cycles for addr %h", waited, addr);
    end
    resp_pending = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    data_req = 1'b0;
    repeat (n) @(negedge clk);
    resp_pending = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (data_ack) begin
          checkOutput("ack_single_pulse", 32'(prev_ack), 32'h0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_ack: ack with empty scoreboard at edge %0d", edge_cnt);
          end else begin
            e = exp_q.pop_front();
            checkOutput("rd_data", data_rd_data, e.rd);
            checkOutput("err", 32'(data_err), 32'(e.err));
            checkOutput("ack_edge", 32'(edge_cnt), 32'(e.ack_edge));
          end
        end else begin
          checkOutput("err_without_ack", 32'(data_err), 32'h0);
        end
        prev_ack = data_ack;
      end else begin
        prev_ack = 1'b0;
      end
    end
  end

  initial begin : stimulus
    logic [31:0] oor_list [4];
    logic [31:0] addr;
    int          pick;
    int          ns;
    int          wait_n;

    oor_list[0] = BASE + DEPTH * 4;
    oor_list[1] = 32'hFFFF_FFFC;
    oor_list[2] = BASE - 32'd4;
    oor_list[3] = 32'h0000_0000;

    rstz = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ack", 32'(data_ack), 32'h0);
    checkOutput("reset_err", 32'(data_err), 32'h0);
    checkOutput("reset_rd", data_rd_data, 32'h0);
    rstz   = 1'b1;
    mon_on = 1'b1;
    idleCycles(2);

    for (int i = 0; i < 16; i++) applyStimulus(BASE + 32'(i * 4), $urandom, 4'hF, 1'b1, 0);
    applyStimulus(BASE + (DEPTH - 1) * 4, $urandom, 4'hF, 1'b1, 0);
    idleCycles(1);

    applyStimulus(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 0);
    applyStimulus(BASE + 32'h10, 32'h0, 4'h0, 1'b0, 0);
    checkOutput("load_full_word", data_rd_data, 32'hDEADBEEF);
    applyStimulus(BASE + 32'h10, 32'h0000AA00, 4'b0010, 1'b1, 0);
    applyStimulus(BASE + 32'h13, 32'h0, 4'h0, 1'b0, 0);
    checkOutput("lane_merge", data_rd_data, 32'hDEADAAEF);
    idleCycles(1);

    applyStimulus(BASE + 32'h4, 32'h0, 4'h0, 1'b0, 2);
    applyStimulus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 0);
    idleCycles(1);

    applyStimulus(oor_list[0], 32'h0, 4'h0, 1'b0, 0);
    checkOutput("oor_top_rd", data_rd_data, 32'h0);
    applyStimulus(oor_list[1], 32'h0, 4'h0, 1'b0, 0);
    applyStimulus(oor_list[2], 32'h0, 4'h0, 1'b0, 1);
    applyStimulus(oor_list[0], 32'hCAFEF00D, 4'hF, 1'b1, 0);
    applyStimulus(BASE + (DEPTH - 1) * 4, 32'h0, 4'h0, 1'b0, 0);
    idleCycles(1);

    applyStimulus(BASE + 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1, 0);
    applyStimulus(BASE + 32'h10, 32'h0, 4'h0, 1'b0, 0);
    checkOutput("mask0_unchanged", data_rd_data, 32'hDEADAAEF);
    idleCycles(1);

    data_addr    = BASE + 32'h20;
    data_wr_data = 32'h12345678;
    data_mask    = 4'hF;
    data_wr_en   = 1'b1;
    data_req     = 1'b1;
    @(negedge clk);
    rstz = 1'b0;
    @(negedge clk);
    rstz     = 1'b1;
    data_req = 1'b0;
    checkOutput("midreset_ack", 32'(data_ack), 32'h0);
    checkOutput("midreset_err", 32'(data_err), 32'h0);
    checkOutput("midreset_rd", data_rd_data, 32'h0);
    last_rd = '0;
    idleCycles(5);
    applyStimulus(BASE + 32'h20, 32'h0, 4'h0, 1'b0, 0);
    idleCycles(1);

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
      pick = $urandom_range(0, 9);
      if (pick < 8) begin
        pick = $urandom_range(0, 16);
        if (pick == 16) pick = DEPTH - 1;
        addr = BASE + 32'(pick * 4) + 32'($urandom_range(0, 3));
      end else begin
        addr = oor_list[$urandom_range(0, 3)];
      end
      ns = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(addr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ns);
    end

    idleCycles(2);
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
